stream_pattern_gen: RTL and testbench
=====================================

STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

Interface
REQ-001 SHALL have parameter C_PIXEL_WIDTH, default 8: total pixel width in bits.
REQ-002 SHALL have parameter C_RESO_WIDTH, default 10: width of resolution and coordinate fields.
REQ-003 SHALL have parameters C_CH0_WIDTH, C_CH1_WIDTH and C_CH2_WIDTH, defaults 8/0/0: channel widths packed from bit 0 upward; a width of 0 means the channel is absent.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port fsync, input, 1 bit: single-cycle frame start request.
REQ-007 SHALL have port m_width, input, C_RESO_WIDTH bits: pixels per line, sampled on fsync.
REQ-008 SHALL have port m_height, input, C_RESO_WIDTH bits: lines per frame, sampled on fsync.
REQ-009 SHALL have port mode, input, 2 bits: pattern select, sampled on fsync.
REQ-010 SHALL have port color, input, C_PIXEL_WIDTH bits: solid fill value, sampled on fsync.
REQ-011 SHALL have ports m_axis_tvalid (out, 1), m_axis_tdata (out, C_PIXEL_WIDTH), m_axis_tuser (out, 1), m_axis_tlast (out, 1) and m_axis_tready (in, 1): AXI4-Stream video master.
REQ-012 SHALL have port busy, output, 1 bit: asserted while the FSM is in RUN.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last pixel of a frame is accepted.
REQ-014 SHALL have port frame_cnt, output, 16 bits: count of completed frames, wrapping.

Function
REQ-015 SHALL implement two states: IDLE and RUN.
REQ-016 SHALL, in IDLE on fsync with sampled width≥1 and height≥1, latch all config, clear x/y to 0 and enter RUN; m_axis_tvalid SHALL rise on the next clock edge.
REQ-017 SHALL stay in IDLE with tvalid low on fsync when width=0 or height=0; frame_done and frame_cnt SHALL NOT change.
REQ-018 SHALL, in RUN, hold tvalid=1 continuously until the final beat; tdata/tuser/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-019 SHALL advance one beat per cycle on tvalid&&tready, giving full throughput with no bubbles.
REQ-020 SHALL assert tuser only on beat (x=0, y=0) and tlast only on beats with x=width-1.
REQ-021 SHALL, on acceptance of beat (width-1, height-1), drop tvalid, pulse frame_done, increment frame_cnt and return to IDLE.
REQ-022 SHALL generate per-channel content for coordinate (x, y): mode 0 = color; mode 1 = x; mode 2 = y; mode 3 = all ones when (x[3]^y[3])=1, else zero.
REQ-023 SHALL form ramp channel values from the low CHn_WIDTH bits of the coordinate (wrap, no saturation); bits of tdata above the channel sum SHALL be zero.
REQ-024 SHALL treat fsync in RUN, including fsync in the same cycle as the final accept, as abort-and-restart: re-sample config and begin a new frame at (0,0) with tuser=1 on the next cycle; the aborted frame SHALL NOT produce frame_done or increment frame_cnt.
REQ-025 SHALL handle width=1 by asserting tuser and tlast together on beat (0,0), and tlast on every beat.
REQ-026 SHALL ignore config input changes made outside fsync.

Reset
REQ-027 SHALL, while resetn=0, asynchronously force: state=IDLE, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, frame_done=0, frame_cnt=0, and x/y/latched config=0.
REQ-028 SHALL emit no beat until the first fsync after resetn deasserts.

Structure
REQ-029 SHALL place the mode encodings (SOLID=0, HRAMP=1, VRAMP=2, CHECK=3) and the state encodings in a shared package vid_pkg.
REQ-030 SHALL implement the x/y coordinate counter as sub-module raster_counter, providing en, clear, width, height, x, y, line_end and frame_end.
REQ-031 SHALL register all outputs; no output SHALL be a combinational function of m_axis_tready.

Verification
REQ-032 SHALL check: width=4, height=2, mode 1, tready=1 -> 8 consecutive beats; tdata 0,1,2,3,0,1,2,3; tuser on beat 0; tlast on beats 3 and 7; frame_done on beat 7; frame_cnt=1.
REQ-033 SHALL check: mode 0, color=0x5A, tready randomly toggled -> every beat equals 0x5A; beats held stable during stalls; exactly width×height beats accepted.
REQ-034 SHALL check: fsync after 3 beats of a 4×4 frame -> next beat is (0,0) with tuser=1; frame_cnt unchanged until the restarted frame completes.
REQ-035 SHALL check: fsync with width=0 -> tvalid stays 0 and busy stays 0.
REQ-036 SHALL check: width=1, height=3 -> 3 beats, all with tlast=1, tuser only on the first.
REQ-037 SHALL check: resetn pulled low mid-frame without a clock edge -> tvalid=0 and frame_cnt=0 immediately.

Source files
------------

// File: rtl/vid_pkg.sv
// ---------------------------------------------------------------------------
// vid_pkg
//   Shared encodings for the video test-pattern blocks.
//   mode_t  : pattern selector carried on the 2-bit mode port.
//   state_t : frame sequencer states.
// ---------------------------------------------------------------------------
package vid_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,  // every channel carries the fill colour
    MODE_HRAMP = 2'd1,  // every channel carries x
    MODE_VRAMP = 2'd2,  // every channel carries y
    MODE_CHECK = 2'd3   // 8x8 checkerboard, all-ones / all-zeros tiles
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Coordinate bit that selects the checkerboard tile (tiles are 8 pixels).
  localparam int CHECK_BIT = 3;

endpackage

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
//   Raster-order x/y coordinate counter for one frame.
//   clk, resetn     : clock, asynchronous active-low reset
//   en              : advance one pixel (x first, then y)
//   clear           : return to (0,0); has priority over en
//   width, height   : frame dimensions (both assumed >= 1 while counting)
//   x, y            : current coordinate
//   line_end        : x is the last pixel of the line
//   frame_end       : coordinate is the last pixel of the frame
// ---------------------------------------------------------------------------
module raster_counter
  import vid_pkg::*;
#(
  parameter int C_RESO_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    clear,
  input  logic [C_RESO_WIDTH-1:0] width,
  input  logic [C_RESO_WIDTH-1:0] height,
  output logic [C_RESO_WIDTH-1:0] x,
  output logic [C_RESO_WIDTH-1:0] y,
  output logic                    line_end,
  output logic                    frame_end
);

  localparam logic [C_RESO_WIDTH-1:0] ONE = C_RESO_WIDTH'(1);

  always_comb begin
    line_end  = (x == width - ONE);
    frame_end = line_end && (y == height - ONE);
  end

  // NOTE: clocked state is always written with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (line_end) begin
        x <= '0;
        y <= frame_end ? '0 : y + ONE;
      end else begin
        x <= x + ONE;
      end
    end
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// ---------------------------------------------------------------------------
// stream_pattern_gen
//   AXI4-Stream video test-pattern generator. A frame starts on fsync with
//   the configuration sampled in that cycle and streams width*height beats
//   in raster order. fsync during a frame aborts it and restarts at (0,0).
//
//   clk, resetn         : clock, asynchronous active-low reset
//   fsync               : single-cycle frame start / restart request
//   m_width, m_height   : frame size, sampled on fsync (0 = ignore request)
//   mode, color         : pattern select and solid fill, sampled on fsync
//   m_axis_t*           : AXI4-Stream master (tuser = start of frame,
//                         tlast = end of line)
//   busy                : high while a frame is being streamed
//   frame_done          : one-cycle pulse after the last beat is accepted
//   frame_cnt           : completed-frame counter, wraps at 16 bits
//
//   Channel n occupies C_CHn_WIDTH bits of tdata, packed upward from bit 0;
//   tdata bits above the channels are always zero.
// ---------------------------------------------------------------------------
module stream_pattern_gen
  import vid_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_RESO_WIDTH  = 10,
  parameter int C_CH0_WIDTH   = 8,
  parameter int C_CH1_WIDTH   = 0,
  parameter int C_CH2_WIDTH   = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     fsync,
  input  logic [C_RESO_WIDTH-1:0]  m_width,
  input  logic [C_RESO_WIDTH-1:0]  m_height,
  input  logic [1:0]               mode,
  input  logic [C_PIXEL_WIDTH-1:0] color,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt
);

  localparam int PW = C_PIXEL_WIDTH;
  localparam int RW = C_RESO_WIDTH;
  localparam int EW = PW + RW;  // coordinate zero-extended past any shift

  localparam int CH0_LO = 0;
  localparam int CH1_LO = C_CH0_WIDTH;
  localparam int CH2_LO = C_CH0_WIDTH + C_CH1_WIDTH;

  localparam logic [RW-1:0] ONE = RW'(1);

  // Bit mask covering w bits starting at lo (w = 0 gives an empty mask).
  function automatic logic [PW-1:0] field_mask(input int lo, input int w);
    return PW'(((64'd1 << w) - 64'd1) << lo);
  endfunction

  localparam logic [PW-1:0] CH0_MASK = field_mask(CH0_LO, C_CH0_WIDTH);
  localparam logic [PW-1:0] CH1_MASK = field_mask(CH1_LO, C_CH1_WIDTH);
  localparam logic [PW-1:0] CH2_MASK = field_mask(CH2_LO, C_CH2_WIDTH);
  localparam logic [PW-1:0] ALL_MASK = CH0_MASK | CH1_MASK | CH2_MASK;

  // Copy the low bits of a coordinate into every present channel; the mask
  // drops coordinate bits beyond the channel width, so ramps wrap.
  function automatic logic [PW-1:0] ramp(input logic [EW-1:0] c);
    return (PW'(c << CH0_LO) & CH0_MASK) |
           (PW'(c << CH1_LO) & CH1_MASK) |
           (PW'(c << CH2_LO) & CH2_MASK);
  endfunction

  function automatic logic [PW-1:0] pixel_value(input mode_t         m,
                                                input logic [PW-1:0] c,
                                                input logic [RW-1:0] px,
                                                input logic [RW-1:0] py);
    logic [PW-1:0] v;
    v = '0;
    case (m)
      MODE_SOLID: v = c & ALL_MASK;
      MODE_HRAMP: v = ramp({{PW{1'b0}}, px});
      MODE_VRAMP: v = ramp({{PW{1'b0}}, py});
      MODE_CHECK: v = (px[CHECK_BIT] ^ py[CHECK_BIT]) ? ALL_MASK : '0;
      default:    v = '0;
    endcase
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [RW-1:0]   width_q, height_q;
  mode_t           mode_q, mode_in;
  logic [PW-1:0]   color_q;

  logic [RW-1:0]   x, y, x_nxt, y_nxt;
  logic            line_end, frame_end;
  logic            cfg_ok, start, accept, cnt_en;

  always_comb begin
    mode_in = mode_t'(mode);
    cfg_ok  = (m_width != '0) && (m_height != '0);
    start   = fsync && cfg_ok;
    accept  = m_axis_tvalid && m_axis_tready;
    // fsync overrides an accept in the same cycle, so the counter only moves
    // on a plain accept.
    cnt_en  = (state_q == ST_RUN) && accept && !fsync;
    // Coordinate of the beat that follows the one currently on the bus; the
    // output registers are loaded from it so tdata is ready one cycle early.
    x_nxt   = line_end ? '0 : x + ONE;
    y_nxt   = line_end ? y + ONE : y;
  end

  raster_counter #(
    .C_RESO_WIDTH (RW)
  ) u_raster (
    .clk       (clk),
    .resetn    (resetn),
    .en        (cnt_en),
    .clear     (start),
    .width     (width_q),
    .height    (height_q),
    .x         (x),
    .y         (y),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every variable assigned here gets its default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        // A request with a zero dimension still aborts the running frame.
        if (fsync)                    state_d = cfg_ok ? ST_RUN : ST_IDLE;
        else if (accept && frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      width_q       <= '0;
      height_q      <= '0;
      mode_q        <= MODE_SOLID;
      color_q       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      busy       <= (state_d == ST_RUN);
      if (start) begin
        width_q       <= m_width;
        height_q      <= m_height;
        mode_q        <= mode_in;
        color_q       <= color;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pixel_value(mode_in, color, '0, '0);
        m_axis_tuser  <= 1'b1;
        m_axis_tlast  <= (m_width == ONE);
      end else if (fsync) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else if ((state_q == ST_RUN) && accept) begin
        m_axis_tuser <= 1'b0;
        if (frame_end) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          frame_done    <= 1'b1;
          frame_cnt     <= frame_cnt + 16'd1;
        end else begin
          m_axis_tdata <= pixel_value(mode_q, color_q, x_nxt, y_nxt);
          m_axis_tlast <= (x_nxt == width_q - ONE);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_stream_pattern_gen
//   Self-checking bench for stream_pattern_gen (default 8/0/0 channels).
//   Expected beats come from a raster model: beat n of a WxH frame is at
//   (n % W, n / W) and its value follows the pattern rules directly.
// ---------------------------------------------------------------------------
module tb_stream_pattern_gen;

  logic        clk;
  logic        resetn;
  logic        fsync;
  logic [9:0]  m_width;
  logic [9:0]  m_height;
  logic [1:0]  mode;
  logic [7:0]  color;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  stream_pattern_gen dut (
    .clk           (clk),
    .resetn        (resetn),
    .fsync         (fsync),
    .m_width       (m_width),
    .m_height      (m_height),
    .mode          (mode),
    .color         (color),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pattern rules for a single 8-bit channel.
  function automatic logic [7:0] ref_pixel(input int m, input int c, input int px, input int py);
    case (m)
      0:       return 8'(c);
      1:       return 8'(px % 256);
      2:       return 8'(py % 256);
      default: return (((px / 8) + (py / 8)) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Present fsync with a configuration for one cycle; returns at the next
  // falling edge. Afterwards the config inputs are scrambled: they must be
  // ignored outside fsync.
  task automatic start_frame(input int w, input int h, input int m, input int c);
    m_width  = 10'(w);
    m_height = 10'(h);
    mode     = 2'(m);
    color    = 8'(c);
    fsync    = 1'b1;
    @(negedge clk);
    fsync    = 1'b0;
    m_width  = 10'($urandom);
    m_height = 10'($urandom);
    mode     = 2'($urandom);
    color    = 8'($urandom);
  endtask

  // Check one presented beat against the model.
  task automatic check_beat(input int idx, input int w, input int m, input int c);
    check("tvalid", m_axis_tvalid, 1);
    check("tdata", m_axis_tdata, ref_pixel(m, c, idx % w, idx / w));
    check("tuser", m_axis_tuser, idx == 0);
    check("tlast", m_axis_tlast, (idx % w) == (w - 1));
  endtask

  // Stream a whole frame from beat 0 with random back-pressure; called at the
  // falling edge where beat 0 is on the bus.
  task automatic stream_frame(input int w, input int h, input int m, input int c,
                              input int ready_pct, output int cycles);
    int idx;
    int budget;
    idx    = 0;
    cycles = 0;
    budget = w * h * 40 + 100;
    while (idx < w * h) begin
      if (cycles >= budget) begin
        check("frame_timeout", idx, w * h);
        break;
      end
      if (m_axis_tvalid !== 1'b1) begin
        check("tvalid_gap", m_axis_tvalid, 1);
        break;
      end
      check_beat(idx, w, m, c);
      check("busy", busy, 1);
      check("frame_done_early", frame_done, 0);
      check("frame_cnt_hold", frame_cnt, exp_frames);
      m_axis_tready = ($urandom_range(0, 99) < ready_pct);
      if (m_axis_tready) idx++;
      @(negedge clk);
      cycles++;
    end
    if (idx == w * h) begin
      exp_frames++;
      check("tvalid_end", m_axis_tvalid, 0);
      check("frame_done", frame_done, 1);
      check("frame_cnt", frame_cnt, exp_frames);
      check("busy_end", busy, 0);
      @(negedge clk);
      check("frame_done_pulse", frame_done, 0);
      check("tvalid_idle", m_axis_tvalid, 0);
    end
  endtask

  initial begin
    int cyc;
    resetn = 1'b0;
    fsync = 1'b0;
    m_width = '0;
    m_height = '0;
    mode = '0;
    color = '0;
    m_axis_tready = 1'b0;

    // Reset state
    #23;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;

    // No beat before the first fsync, even with tready high
    m_axis_tready = 1'b1;
    m_width = 10'd4;
    m_height = 10'd4;
    repeat (4) begin
      @(negedge clk);
      check("pre_fsync_tvalid", m_axis_tvalid, 0);
    end

    // 4x2 horizontal ramp at full throughput
    start_frame(4, 2, 1, 0);
    stream_frame(4, 2, 1, 0, 100, cyc);
    check("hramp_cycles", cyc, 8);

    // Solid 0x5A with random stalls
    start_frame(6, 3, 0, 'h5A);
    stream_frame(6, 3, 0, 'h5A, 45, cyc);

    // Zero width / zero height requests are ignored
    start_frame(0, 3, 1, 0);
    repeat (3) begin
      check("w0_tvalid", m_axis_tvalid, 0);
      check("w0_busy", busy, 0);
      check("w0_frame_done", frame_done, 0);
      check("w0_frame_cnt", frame_cnt, exp_frames);
      @(negedge clk);
    end
    start_frame(5, 0, 1, 0);
    repeat (2) begin
      check("h0_tvalid", m_axis_tvalid, 0);
      check("h0_busy", busy, 0);
      @(negedge clk);
    end

    // Width 1: every beat is end of line
    start_frame(1, 3, 2, 0);
    stream_frame(1, 3, 2, 0, 70, cyc);

    // Abort after 3 beats of a 4x4 frame; restart in a different mode
    start_frame(4, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check_beat(i, 4, 1, 0);
      m_axis_tready = 1'b1;
      @(negedge clk);
    end
    check_beat(3, 4, 1, 0);
    start_frame(4, 4, 2, 0);
    check("abort_frame_done", frame_done, 0);
    check("abort_frame_cnt", frame_cnt, exp_frames);
    stream_frame(4, 4, 2, 0, 80, cyc);

    // fsync coinciding with acceptance of the final beat restarts instead
    start_frame(2, 1, 1, 0);
    check_beat(0, 2, 1, 0);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check_beat(1, 2, 1, 0);
    start_frame(3, 2, 0, 'hC3);
    check("final_abort_done", frame_done, 0);
    check("final_abort_cnt", frame_cnt, exp_frames);
    stream_frame(3, 2, 0, 'hC3, 100, cyc);

    // Horizontal ramp wrapping past 255, and the checkerboard
    start_frame(300, 1, 1, 0);
    stream_frame(300, 1, 1, 0, 100, cyc);
    check("wrap_cycles", cyc, 300);
    start_frame(20, 18, 3, 0);
    stream_frame(20, 18, 3, 0, 90, cyc);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      int w, h, m, c, p;
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 5);
      m = $urandom_range(0, 3);
      c = $urandom_range(0, 255);
      p = $urandom_range(30, 100);
      start_frame(w, h, m, c);
      stream_frame(w, h, m, c, p, cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a frame
    start_frame(8, 4, 1, 0);
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    exp_frames = 0;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_frame_cnt", frame_cnt, exp_frames);
    check("async_rst_busy", busy, 0);
    check("async_rst_tuser", m_axis_tuser, 0);
    check("async_rst_tdata", m_axis_tdata, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_tvalid", m_axis_tvalid, 0);
    end
    start_frame(3, 2, 2, 0);
    stream_frame(3, 2, 2, 0, 60, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
